// File: rtl/comprobador_pkg.sv
// Shared types and helpers for the signed division checker.
// The helpers are fixed at the default operand width TAMANYO.
package comprobador_pkg;

  localparam int unsigned TAMANYO = 32;

  typedef enum logic [1:0] {IDLE, MUL, CHECK, DONE} estado_t;
  typedef enum logic       {M_IDLE, M_RUN}          mult_estado_t;

  // Magnitude of a two's-complement value; the most negative value maps to 2^(TAMANYO-1).
  function automatic logic [TAMANYO-1:0] abs_mag(input logic [TAMANYO-1:0] x);
    return x[TAMANYO-1] ? (~x + TAMANYO'(1)) : x;
  endfunction

  function automatic logic [2*TAMANYO-1:0] sext2(input logic [TAMANYO-1:0] x);
    return {{TAMANYO{x[TAMANYO-1]}}, x};
  endfunction

endpackage

// File: rtl/comprobador_division_mult.sv
// Unsigned shift-add multiplier, one bit of i_a per cycle, LSB first.
// o_done is high during the cycle whose edge completes the product.
module mult_secuencial
  import comprobador_pkg::*;
#(
  parameter int unsigned W = TAMANYO
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);

  localparam int unsigned CW = $clog2(W);

  mult_estado_t   r_estado, w_estado_sig;
  logic [W-1:0]   r_a;
  logic [2*W-1:0] r_b_sh;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           w_last;

  assign w_last = (r_estado == M_RUN) && (r_cnt == CW'(W-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_estado <= M_IDLE;
    else          r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      M_IDLE:  if (i_start) w_estado_sig = M_RUN;
      M_RUN:   if (w_last)  w_estado_sig = M_IDLE;
      default: w_estado_sig = M_IDLE;
    endcase
  end

  // i_a shifts right and i_b shifts left so bit k of i_a always meets i_b << k.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_estado == M_IDLE) begin
      if (i_start) begin
        r_a    <= i_a;
        r_b_sh <= {{W{1'b0}}, i_b};
        r_acc  <= '0;
        r_cnt  <= '0;
      end
    end else begin
      if (r_a[0]) r_acc <= r_acc + r_b_sh;
      r_a    <= r_a >> 1;
      r_b_sh <= r_b_sh << 1;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_done = w_last;
  assign o_prod = r_acc;

endmodule

// File: rtl/comprobador_division.sv
// Sequential checker for a signed division result: verifies Coc*Den + Res == Num
// at double precision plus the remainder sign and magnitude rules.
module comprobador_division
  import comprobador_pkg::*;
#(
  parameter int unsigned tamanyo = TAMANYO
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Res,
  output logic               Busy,
  output logic               Done,
  output logic               Ok,
  output logic               Err_mul,
  output logic               Err_rem,
  output logic               Err_den
);

  estado_t r_estado, w_estado_sig;

  logic [tamanyo-1:0]   r_num, r_den, r_res;
  logic                 r_neg;
  logic                 r_ok, r_err_mul, r_err_rem, r_err_den;
  logic                 w_acepta, w_mul_fin;
  logic [2*tamanyo-1:0] w_acc, w_p, w_res2, w_num2;
  logic [2*tamanyo:0]   w_s;
  logic                 w_err_mul, w_err_rem, w_err_den;

  assign w_acepta = (r_estado == IDLE) && Start;

  mult_secuencial #(.W(tamanyo)) u_mult (
    .i_clk   (CLK),
    .i_rst_n (RSTa),
    .i_start (w_acepta),
    .i_a     (abs_mag(Coc)),
    .i_b     (abs_mag(Den)),
    .o_done  (w_mul_fin),
    .o_prod  (w_acc)
  );

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) r_estado <= IDLE;
    else       r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:    if (Start)     w_estado_sig = MUL;
      MUL:     if (w_mul_fin) w_estado_sig = CHECK;
      CHECK:   w_estado_sig = DONE;
      DONE:    w_estado_sig = IDLE;
      default: w_estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_num <= '0;
      r_den <= '0;
      r_res <= '0;
      r_neg <= 1'b0;
    end else if (w_acepta) begin
      r_num <= Num;
      r_den <= Den;
      r_res <= Res;
      r_neg <= Coc[tamanyo-1] ^ Den[tamanyo-1];
    end
  end

  // |Coc|*|Den| <= 2^(2*tamanyo-2), so the negated product still fits in 2*tamanyo bits.
  assign w_p    = r_neg ? -w_acc : w_acc;
  assign w_res2 = sext2(r_res);
  assign w_num2 = sext2(r_num);
  assign w_s    = {w_p[2*tamanyo-1], w_p} + {w_res2[2*tamanyo-1], w_res2};

  assign w_err_den = (r_den == '0);
  assign w_err_mul = (w_s != {w_num2[2*tamanyo-1], w_num2});
  assign w_err_rem = !((r_res == '0) || (r_res[tamanyo-1] == r_num[tamanyo-1]))
                     || ({1'b0, abs_mag(r_res)} >= {1'b0, abs_mag(r_den)});

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      r_ok      <= 1'b0;
      r_err_mul <= 1'b0;
      r_err_rem <= 1'b0;
      r_err_den <= 1'b0;
    end else if (w_acepta) begin
      r_ok      <= 1'b0;
      r_err_mul <= 1'b0;
      r_err_rem <= 1'b0;
      r_err_den <= 1'b0;
    end else if (r_estado == CHECK) begin
      r_err_den <= w_err_den;
      r_err_mul <= w_err_mul && !w_err_den;
      r_err_rem <= w_err_rem && !w_err_den;
      r_ok      <= !w_err_den && !w_err_mul && !w_err_rem;
    end
  end

  assign Busy    = (r_estado != IDLE);
  assign Done    = (r_estado == DONE);
  assign Ok      = r_ok;
  assign Err_mul = r_err_mul;
  assign Err_rem = r_err_rem;
  assign Err_den = r_err_den;

endmodule

// File: tb/tb_comprobador_division.sv
// Randomized self-checking bench for comprobador_division against an arithmetic model.
module tb_comprobador_division;

  logic        CLK = 1'b0;
  logic        RSTa = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Num = '0, Den = '0, Coc = '0, Res = '0;
  logic        Busy, Done, Ok, Err_mul, Err_rem, Err_den;

  int n_checks = 0;
  int n_errors = 0;

  comprobador_division #(.tamanyo(32)) dut (
    .CLK     (CLK),
    .RSTa    (RSTa),
    .Start   (Start),
    .Num     (Num),
    .Den     (Den),
    .Coc     (Coc),
    .Res     (Res),
    .Busy    (Busy),
    .Done    (Done),
    .Ok      (Ok),
    .Err_mul (Err_mul),
    .Err_rem (Err_rem),
    .Err_den (Err_den)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on 64-bit signed values.
  task automatic modelo(input int n, input int d, input int c, input int r,
                        output bit ok, output bit em, output bit er, output bit ed);
    longint s, ar, ad;
    s  = longint'(c) * longint'(d) + longint'(r);
    ar = (r < 0) ? -longint'(r) : longint'(r);
    ad = (d < 0) ? -longint'(d) : longint'(d);
    ed = (d == 0);
    em = !ed && (s != longint'(n));
    er = !ed && (!((r == 0) || ((r < 0) == (n < 0))) || (ar >= ad));
    ok = !(ed || em || er);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_check(input int n, input int d, input int c, input int r, input bit repulse);
    bit eok, eem, eer, eed;
    int cyc;
    bit seen;
    modelo(n, d, c, r, eok, eem, eer, eed);
    Num = n; Den = d; Coc = c; Res = r; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    Num = $urandom; Den = $urandom; Coc = $urandom; Res = $urandom;
    check("busy_start", Busy, 1);
    check("flags_clear", {Ok, Err_mul, Err_rem, Err_den}, 0);
    cyc = 0;
    seen = 0;
    while (cyc < 100 && !seen) begin
      @(posedge CLK); #1;
      cyc++;
      Start = repulse && (cyc == 5 || cyc == 33);
      if (Start) begin
        Num = 100; Den = 7; Coc = $urandom; Res = $urandom;
      end
      if (Done) seen = 1;
    end
    check("latency", cyc, 33);
    check("ok", Ok, eok);
    check("err_mul", Err_mul, eem);
    check("err_rem", Err_rem, eer);
    check("err_den", Err_den, eed);
    @(posedge CLK); #1;
    Start = 1'b0;
    check("done_pulse", Done, 0);
    check("busy_end", Busy, 0);
    @(posedge CLK); #1;
    check("idle_after", {Busy, Done}, 0);
    check("flags_hold", {Ok, Err_mul, Err_rem, Err_den}, {eok, eem, eer, eed});
  endtask

  task automatic reset_mid_check();
    Num = 100; Den = 7; Coc = 14; Res = 2; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RSTa = 1'b0;
    #1;
    check("reset_mid", {Busy, Done, Ok, Err_mul, Err_rem, Err_den}, 0);
    @(posedge CLK); #1;
    check("reset_hold", {Busy, Done}, 0);
    RSTa = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int n, d, c, r;
    longint q, rm;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", {Busy, Done, Ok, Err_mul, Err_rem, Err_den}, 0);
    RSTa = 1'b1;
    @(posedge CLK); #1;

    run_check(100, 7, 14, 2, 0);
    run_check(-100, 7, -14, -2, 0);
    run_check(-100, 7, -14, 2, 0);
    run_check(100, 7, 13, 9, 0);
    run_check(100, 7, 14, 3, 0);
    run_check(int'(32'h8000_0000), -1, int'(32'h8000_0000), 0, 0);
    run_check(5, 0, $urandom, $urandom, 0);
    run_check(100, 7, 14, 2, 1);
    run_check(-100, 7, -14, -2, 1);
    reset_mid_check();
    run_check(-100, 7, -14, -2, 0);

    for (int i = 0; i < 40; i++) begin
      n = $urandom;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = int'($urandom_range(0, 40)) - 20;
        2:       d = int'($urandom_range(0, 65535)) - 32768;
        default: d = $urandom;
      endcase
      if (d == 0) begin
        c = $urandom; r = $urandom;
      end else begin
        q  = longint'(n) / longint'(d);
        rm = longint'(n) % longint'(d);
        c  = int'(q);
        r  = int'(rm);
        case ($urandom_range(0, 4))
          0: c = c + 1;
          1: r = r - 1;
          2: r = $urandom;
          default: ;
        endcase
      end
      run_check(n, d, c, r, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
